// File: rtl/raycast_pkg.sv
// Shared raycasting constants: screen geometry, column widths and the frame
// sequencer state encoding that the mmap status register exposes.
package raycast_pkg;

  localparam int SCREEN_W_DEFAULT = 320;
  localparam int COL_W            = 9;
  // One extra bit so a full 512-column frame can still be counted.
  localparam int CNT_W            = COL_W + 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SPRITE    = 3'd1;
  localparam logic [2:0] ST_CAST      = 3'd2;
  localparam logic [2:0] ST_WAIT_CAST = 3'd3;
  localparam logic [2:0] ST_ISSUE     = 3'd4;
  localparam logic [2:0] ST_DRAIN     = 3'd5;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic [CNT_W-1:0] limit
  );
    logic [CNT_W-1:0] res;
    if (inc && (cnt < limit)) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: sprite transform, then one ray cast per column with the
// line write of column x overlapping the cast of column x+1.
module frame_sequencer
  import raycast_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEFAULT,
  parameter bit SPRITES_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             abort,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             sprite_start,
  input  logic             sprite_done,
  output logic [COL_W-1:0] cast_x,
  output logic             cast_start,
  input  logic             cast_busy,
  input  logic             cast_done,
  output logic             line_write_start,
  input  logic             line_write_ready,
  input  logic             line_write_done,
  output logic [COL_W-1:0] cols_written
);

  localparam logic [CNT_W-1:0] COLS_FULL = CNT_W'(SCREEN_W);
  localparam logic [COL_W-1:0] LAST_X    = COL_W'(SCREEN_W - 1);

  logic [2:0]       state_r, state_s;
  logic [COL_W-1:0] cast_x_r, cast_x_s;
  logic [CNT_W-1:0] cols_r, cols_s;
  logic             busy_r, busy_s;
  logic             frame_done_r, frame_done_s;
  logic             sprite_start_r, sprite_start_s;
  logic             cast_start_r, cast_start_s;
  logic             lw_start_r, lw_start_s;
  logic [2:0]       launch_state_s;
  logic             launch_pulse_s;

  // Where a cast request lands: start now if the caster is free, else wait in CAST.
  always_comb begin
    if (cast_busy) begin
      launch_state_s = ST_CAST;
      launch_pulse_s = 1'b0;
    end else begin
      launch_state_s = ST_WAIT_CAST;
      launch_pulse_s = 1'b1;
    end
  end

  // Next-state, next-counter and next-pulse decisions.
  always_comb begin
    state_s        = state_r;
    cast_x_s       = cast_x_r;
    cols_s         = sat_inc(cols_r, line_write_done, COLS_FULL);
    sprite_start_s = 1'b0;
    cast_start_s   = 1'b0;
    lw_start_s     = 1'b0;
    frame_done_s   = 1'b0;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A request coinciding with the done pulse belongs to the old frame.
          if (frame_start && !frame_done_r) begin
            cast_x_s = {COL_W{1'b0}};
            cols_s   = {CNT_W{1'b0}};
            if (SPRITES_EN) begin
              sprite_start_s = 1'b1;
              state_s        = ST_SPRITE;
            end else begin
              state_s      = launch_state_s;
              cast_start_s = launch_pulse_s;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SPRITE: begin
          if (sprite_done) begin
            state_s      = launch_state_s;
            cast_start_s = launch_pulse_s;
          end else begin
            state_s = ST_SPRITE;
          end
        end
        ST_CAST: begin
          state_s      = launch_state_s;
          cast_start_s = launch_pulse_s;
        end
        ST_WAIT_CAST: begin
          if (cast_done) begin
            state_s    = ST_ISSUE;
            lw_start_s = line_write_ready;
          end else begin
            state_s = ST_WAIT_CAST;
          end
        end
        ST_ISSUE: begin
          // cast_x only moves once the line writer has latched this column.
          if (lw_start_r) begin
            if (cast_x_r == LAST_X) begin
              state_s = ST_DRAIN;
            end else begin
              cast_x_s     = cast_x_r + {{(COL_W-1){1'b0}}, 1'b1};
              state_s      = launch_state_s;
              cast_start_s = launch_pulse_s;
            end
          end else if (line_write_ready) begin
            lw_start_s = 1'b1;
          end else begin
            state_s = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (cols_s == COLS_FULL) begin
            frame_done_s = 1'b1;
            state_s      = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cast_x_r       <= {COL_W{1'b0}};
      cols_r         <= {CNT_W{1'b0}};
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      sprite_start_r <= 1'b0;
      cast_start_r   <= 1'b0;
      lw_start_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      cast_x_r       <= cast_x_s;
      cols_r         <= cols_s;
      busy_r         <= busy_s;
      frame_done_r   <= frame_done_s;
      sprite_start_r <= sprite_start_s;
      cast_start_r   <= cast_start_s;
      lw_start_r     <= lw_start_s;
    end
  end

  assign frame_busy       = busy_r;
  assign frame_done       = frame_done_r;
  assign sprite_start     = sprite_start_r;
  assign cast_start       = cast_start_r;
  assign line_write_start = lw_start_r;
  assign cast_x           = cast_x_r;
  assign cols_written     = cols_r[COL_W-1:0];

endmodule
